// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register: valid/ready handshake, 2-entry skid buffer, flush, bubble zeroing.
// Optional performance counters (stall_cnt, flush_cnt) are built only when PIPE_STAGE_BUF_PERF_EN is defined.
module pipe_stage_buf #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   main_data_r;
    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic                in_ready_s;
    logic                out_valid_s;
    logic                in_fire_s;
    logic                out_fire_s;
    logic                load_main_in_s;
    logic                load_main_skid_s;
    logic                load_skid_s;

    assign in_fire_s  = in_valid & in_ready_s;
    assign out_fire_s = out_valid_s & out_ready;

    // State register; every update happens on the falling clock edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath load selection; flush overrides every transition.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s    = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_nxt_s    = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_nxt_s = ST_TWO;
                        load_skid_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        state_nxt_s      = ST_ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decode only the registered state, so out_ready never reaches in_ready.
    always_comb begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_ONE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b1;
            end
            ST_TWO: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Main and skid payload registers.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            main_data_r <= {DATA_W{1'b0}};
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
        end else begin
            if (load_main_in_s) begin
                main_data_r <= in_data;
                main_ctrl_r <= in_ctrl;
            end else if (load_main_skid_s) begin
                main_data_r <= skid_data_r;
                main_ctrl_r <= skid_ctrl_r;
            end
            if (load_skid_s) begin
                skid_data_r <= in_data;
                skid_ctrl_r <= in_ctrl;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = main_data_r;
    // A bubble must never carry write enables downstream.
    assign out_ctrl  = out_valid_s ? main_ctrl_r : {CTRL_W{1'b0}};
    assign occupancy = state_r;

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating stall and flush counters, cleared only by reset.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush && (state_r != ST_EMPTY) && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed testbench for pipe_stage_buf; state changes on negedge, outputs sampled just after posedge.
// Counter checks are compiled in when PIPE_STAGE_BUF_PERF_EN is defined.
module tb_pipe_stage_buf;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 16;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    int n_tests;
    int n_fail;

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
    logic              sat_in_ready;
    logic              sat_out_valid;
    logic [DATA_W-1:0] sat_out_data;
    logic [CTRL_W-1:0] sat_out_ctrl;
    logic [1:0]        sat_occupancy;
    logic [1:0]        sat_stall_cnt;
    logic [1:0]        sat_flush_cnt;

    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .out_ctrl(sat_out_ctrl),
        .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt)
    );
`else
    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full cycle: the committing falling edge, then sample point just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        cyc();
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        n_tests++; if (out_ctrl !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl got %h exp 0", out_ctrl); end
        n_tests++; if (out_data !== 96'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push(96'h0123_4567_89AB_CDEF_0000_ABCD, 16'h0005);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b exp 1", out_valid); end
        n_tests++; if (out_data !== 96'h0123_4567_89AB_CDEF_0000_ABCD) begin n_fail++; $display("FAIL single_data got %h", out_data); end
        n_tests++; if (out_ctrl !== 16'h0005) begin n_fail++; $display("FAIL single_ctrl got %h exp 0005", out_ctrl); end
        cyc();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %0b exp 0", out_valid); end
        n_tests++; if (out_ctrl !== 16'h0000) begin n_fail++; $display("FAIL single_bubble_ctrl got %h exp 0", out_ctrl); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            push(DATA_W'(k), CTRL_W'(k));
            n_tests++; if (out_valid !== 1'b1 || out_data !== DATA_W'(k)) begin n_fail++; $display("FAIL stream_data[%0d] got v=%0b d=%0h exp %0d", k, out_valid, out_data, k); end
            n_tests++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got rdy=%0b occ=%0d exp 1/1", k, in_ready, occupancy); end
        end
        in_valid = 1'b0;
        cyc();
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain got occ=%0d exp 0", occupancy); end
    endtask

    task automatic test_stall_fill();
        out_ready = 1'b0;
        push(96'h11, 16'h0001);
        n_tests++; if (occupancy !== 2'd1 || out_data !== 96'h11) begin n_fail++; $display("FAIL fill_first got occ=%0d d=%0h exp 1/11", occupancy, out_data); end
        push(96'h22, 16'h0002);
        n_tests++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got occ=%0d rdy=%0b exp 2/0", occupancy, in_ready); end
        push(96'h33, 16'h0003);
        n_tests++; if (occupancy !== 2'd2 || out_data !== 96'h11 || out_ctrl !== 16'h0001) begin n_fail++; $display("FAIL fill_hold got occ=%0d d=%0h c=%0h exp 2/11/1", occupancy, out_data, out_ctrl); end
        out_ready = 1'b1;
        cyc();
        n_tests++; if (out_data !== 96'h22 || out_ctrl !== 16'h0002 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_second got d=%0h c=%0h rdy=%0b exp 22/2/1", out_data, out_ctrl, in_ready); end
        cyc();
        n_tests++; if (out_data !== 96'h33 || out_valid !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL fill_third got d=%0h v=%0b occ=%0d exp 33/1/1", out_data, out_valid, occupancy); end
        in_valid = 1'b0;
        cyc();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drain got v=%0b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(96'h55, 16'h0005);
        push(96'h66, 16'h0006);
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre got occ=%0d exp 2", occupancy); end
        flush = 1'b1;
        push(96'h44, 16'h0004);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 16'h0000 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full got occ=%0d v=%0b c=%0h rdy=%0b exp 0/0/0/1", occupancy, out_valid, out_ctrl, in_ready); end
        cyc();
        n_tests++; if (out_valid !== 1'b0 || out_data === 96'h44) begin n_fail++; $display("FAIL flush_no_44 got v=%0b d=%0h exp v=0", out_valid, out_data); end
        out_ready = 1'b0;
        push(96'h77, 16'h0007);
        flush = 1'b1;
        push(96'h88, 16'h0008);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one got occ=%0d v=%0b exp 0/0", occupancy, out_valid); end
        cyc();
        n_tests++; if (out_valid !== 1'b0 || out_data === 96'h88) begin n_fail++; $display("FAIL flush_no_88 got v=%0b d=%0h exp v=0", out_valid, out_data); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push(96'hAA, 16'h00AA);
        push(96'hBB, 16'h00BB);
        in_valid = 1'b0;
        n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL areset_pre got occ=%0d exp 2", occupancy); end
        #1;
        rst = 1'b0;
        #1;
        n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 16'h0000) begin n_fail++; $display("FAIL areset_state got occ=%0d v=%0b c=%0h exp 0/0/0", occupancy, out_valid, out_ctrl); end
        n_tests++; if (out_data !== 96'h0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_data got d=%0h rdy=%0b exp 0/1", out_data, in_ready); end
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        push(96'hCC, 16'h00CC);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_data !== 96'hCC) begin n_fail++; $display("FAIL areset_after got v=%0b d=%0h exp 1/CC", out_valid, out_data); end
        cyc();
    endtask

`ifdef PIPE_STAGE_BUF_PERF_EN
    task automatic test_perf();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        n_tests++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL perf_reset got s=%0d f=%0d exp 0/0", stall_cnt, flush_cnt); end
        out_ready = 1'b0;
        push(96'h99, 16'h0009);
        in_valid = 1'b0;
        repeat (5) cyc();
        n_tests++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL perf_stall5 got %0d exp 5", stall_cnt); end
        cyc();
        n_tests++; if (stall_cnt !== 16'd6 || sat_stall_cnt !== 2'd3) begin n_fail++; $display("FAIL perf_stall6 got s=%0d sat=%0d exp 6/3", stall_cnt, sat_stall_cnt); end
        flush     = 1'b1;
        out_ready = 1'b1;
        cyc();
        flush = 1'b0;
        n_tests++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd6 || occupancy !== 2'd0) begin n_fail++; $display("FAIL perf_flush got f=%0d s=%0d occ=%0d exp 1/6/0", flush_cnt, stall_cnt, occupancy); end
        cyc();
        n_tests++; if (flush_cnt !== 16'd1 || sat_flush_cnt !== 2'd1) begin n_fail++; $display("FAIL perf_flush_idle got f=%0d sat=%0d exp 1/1", flush_cnt, sat_flush_cnt); end
    endtask
`endif

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 96'h0;
        in_ctrl   = 16'h0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_async_reset();
`ifdef PIPE_STAGE_BUF_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
